// File: rtl/bip_cpu_if.sv
// -----------------------------------------------------------------------------
// bip_cpu_if
// Bus between the BIP core and its memories: the asynchronous program ROM
// and the data RAM with its held-request / DM_ACK handshake.
//
// Signals
//   INSTRUCTION  ROM -> core  {opcode, operand} addressed by ADDR_PM
//   ADDR_PM      core -> ROM  program counter
//   ADDR_DM      core -> RAM  data address of the outstanding request
//   DM_OUT       core -> RAM  write data (the accumulator)
//   RD / WR      core -> RAM  read / write request, held until DM_ACK
//   DM_IN        RAM -> core  read data, valid with DM_ACK during a read
//   DM_ACK       RAM -> core  request completes at the next rising edge
//
// Modports: master = core side, slave = memory side.
// -----------------------------------------------------------------------------
interface bip_cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int OPC_W  = 5
);
  localparam int INSTR_W = OPC_W + ADDR_W;

  logic [INSTR_W-1:0] INSTRUCTION;
  logic [ADDR_W-1:0]  ADDR_PM;
  logic [ADDR_W-1:0]  ADDR_DM;
  logic [DATA_W-1:0]  DM_OUT;
  logic [DATA_W-1:0]  DM_IN;
  logic               DM_ACK;
  logic               RD;
  logic               WR;

  modport master (
    input  INSTRUCTION, DM_IN, DM_ACK,
    output ADDR_PM, ADDR_DM, DM_OUT, RD, WR
  );

  modport slave (
    output INSTRUCTION, DM_IN, DM_ACK,
    input  ADDR_PM, ADDR_DM, DM_OUT, RD, WR
  );
endinterface

// File: rtl/bip_cpu_core.sv
// -----------------------------------------------------------------------------
// bip_cpu_core
// BIP-I accumulator CPU, control and datapath in one block. Instructions come
// from an asynchronous ROM; data RAM accesses hold RD/WR until DM_ACK, so any
// number of RAM wait states is tolerated. A HLT instruction parks the core in
// HALT until reset; CYCLES counts (saturating) the clocks spent in RUN/MEM.
//
// Optional feature macro: BIP_BRANCH_EN
//   defined   -> zero flag Z plus BEQ (01000), BNE (01001), JMP (01010)
//   undefined -> those opcodes behave as NOP, no Z flag
//
// Ports
//   CLK     in   rising-edge clock
//   RESET   in   asynchronous, active-low reset
//   bus     master modport of bip_cpu_if (ROM + RAM handshake)
//   ACC     out  accumulator
//   HALTED  out  core sits in HALT
//   CYCLES  out  saturating count of clocks in RUN or MEM
// -----------------------------------------------------------------------------
module bip_cpu_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int OPC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  bip_cpu_if.master         bus,
  output logic [DATA_W-1:0] ACC,
  output logic              HALTED,
  output logic [CNT_W-1:0]  CYCLES
);
  localparam int INSTR_W = OPC_W + ADDR_W;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
`ifdef BIP_BRANCH_EN
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(10);
`endif

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MEM  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_addr_dm;
  logic [DATA_W-1:0]  r_acc;
  logic [OPC_W-1:0]   r_mem_op;
  logic               r_rd;
  logic               r_wr;
  logic               r_halted;
  logic [CNT_W-1:0]   r_cycles;
`ifdef BIP_BRANCH_EN
  logic               r_z;
`endif

  logic [OPC_W-1:0]   w_opcode;
  logic [ADDR_W-1:0]  w_operand;
  logic [DATA_W-1:0]  w_imm;
  logic               w_is_mem;
  logic [DATA_W-1:0]  w_acc_nxt;

  assign w_opcode  = bus.INSTRUCTION[INSTR_W-1:ADDR_W];
  assign w_operand = bus.INSTRUCTION[ADDR_W-1:0];
  // Size cast of a signed value sign-extends the operand to DATA_W.
  assign w_imm     = DATA_W'($signed(w_operand));
  assign w_is_mem  = (w_opcode == OP_STO) || (w_opcode == OP_LD) ||
                     (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

  // Next accumulator value. Shared by the ACC and Z registers so the flag
  // always describes the value ACC takes at the same edge.
  always_comb begin
    // NOTE: default assignment first; every path then drives w_acc_nxt, so
    // no latch is inferred.
    w_acc_nxt = r_acc;
    if (r_state == S_RUN) begin
      case (w_opcode)
        OP_LDI:  w_acc_nxt = w_imm;
        OP_ADDI: w_acc_nxt = r_acc + w_imm;
        OP_SUBI: w_acc_nxt = r_acc - w_imm;
        default: w_acc_nxt = r_acc;
      endcase
    end else if (r_state == S_MEM && bus.DM_ACK) begin
      case (r_mem_op)
        OP_LD:   w_acc_nxt = bus.DM_IN;
        OP_ADD:  w_acc_nxt = r_acc + bus.DM_IN;
        OP_SUB:  w_acc_nxt = r_acc - bus.DM_IN;
        default: w_acc_nxt = r_acc;
      endcase
    end
  end

  // Control FSM and all architectural state. Outputs come straight from
  // registers; DM_ACK is only looked at while in MEM.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: non-blocking assignments for all state, so every register
      // samples pre-edge values regardless of statement order.
      r_state   <= S_RUN;
      r_pc      <= '0;
      r_addr_dm <= '0;
      r_acc     <= '0;
      r_mem_op  <= OP_HLT;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_halted  <= 1'b0;
      r_cycles  <= '0;
`ifdef BIP_BRANCH_EN
      r_z       <= 1'b1;
`endif
    end else begin
      r_acc <= w_acc_nxt;
`ifdef BIP_BRANCH_EN
      r_z   <= (w_acc_nxt == '0);
`endif
      if (r_state != S_HALT && r_cycles != '1) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end

      case (r_state)
        S_RUN: begin
          if (w_opcode == OP_HLT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (w_is_mem) begin
            // PC holds; it advances when the RAM acknowledges.
            r_mem_op  <= w_opcode;
            r_addr_dm <= w_operand;
            r_rd      <= (w_opcode != OP_STO);
            r_wr      <= (w_opcode == OP_STO);
            r_state   <= S_MEM;
          end
`ifdef BIP_BRANCH_EN
          else if ((w_opcode == OP_JMP) ||
                   (w_opcode == OP_BEQ &&  r_z) ||
                   (w_opcode == OP_BNE && !r_z)) begin
            r_pc <= w_operand;
          end
`endif
          else begin
            r_pc <= r_pc + ADDR_W'(1);
          end
        end

        S_MEM: begin
          if (bus.DM_ACK) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_RUN;
          end
        end

        S_HALT: begin
          // Frozen until reset.
        end

        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign bus.ADDR_PM = r_pc;
  assign bus.ADDR_DM = r_addr_dm;
  assign bus.DM_OUT  = r_acc;
  assign bus.RD      = r_rd;
  assign bus.WR      = r_wr;
  assign ACC         = r_acc;
  assign HALTED      = r_halted;
  assign CYCLES      = r_cycles;
endmodule

// File: tb/tb_bip_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_bip_cpu_core
// Bench for bip_cpu_core: program ROM and data RAM live in the bench, the RAM
// answers with a queue of wait-state counts, and random programs are checked
// against an instruction-level model of the BIP-I machine. A second instance
// with a 4-bit CYCLES counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_bip_cpu_core;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 11;
  localparam int OPC_W   = 5;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;
  localparam int INSTR_W = OPC_W + ADDR_W;
  localparam int PM_SIZE = 2 ** ADDR_W;
  localparam int PLEN    = 48;
  localparam int N_RUNS  = 8;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;
  localparam logic [4:0] OP_BEQ  = 5'd8;
  localparam logic [4:0] OP_BNE  = 5'd9;
  localparam logic [4:0] OP_JMP  = 5'd10;
  localparam logic [4:0] OP_NOP  = 5'd31;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  logic [DATA_W-1:0] acc;
  logic              halted;
  logic [CNT_W-1:0]  cycles;
  logic [DATA_W-1:0] acc_s;
  logic              halted_s;
  logic [SAT_W-1:0]  cycles_s;

  bip_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();
  bip_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus_s ();

  bip_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) u_dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus    (bus),
    .ACC    (acc),
    .HALTED (halted),
    .CYCLES (cycles)
  );

  // Free-running NOP core used only to see CYCLES saturate.
  bip_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .CNT_W(SAT_W)) u_sat (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus    (bus_s),
    .ACC    (acc_s),
    .HALTED (halted_s),
    .CYCLES (cycles_s)
  );

  assign bus_s.INSTRUCTION = {OP_NOP, 11'h000};
  assign bus_s.DM_IN       = '0;
  assign bus_s.DM_ACK      = 1'b0;

  logic [INSTR_W-1:0] rom [PM_SIZE];
  logic [DATA_W-1:0]  ram [PM_SIZE];

  assign bus.INSTRUCTION = rom[bus.ADDR_PM];

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM responder: each request pops its wait-state count from waits_q, keeps
  // DM_ACK low that many cycles with junk on DM_IN, then acknowledges. While
  // idle DM_ACK toggles randomly, which the core must ignore.
  int waits_q[$];
  int w_left = 0;
  bit armed  = 1'b0;

  always @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      armed      = 1'b0;
      bus.DM_ACK = 1'b0;
      bus.DM_IN  = '0;
    end else if (bus.RD || bus.WR) begin
      if (!armed) begin
        armed  = 1'b1;
        w_left = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
      end
      if (w_left == 0) begin
        bus.DM_ACK = 1'b1;
        bus.DM_IN  = bus.RD ? ram[bus.ADDR_DM] : DATA_W'($urandom);
        if (bus.WR) ram[bus.ADDR_DM] = bus.DM_OUT;
      end else begin
        bus.DM_ACK = 1'b0;
        bus.DM_IN  = DATA_W'($urandom);
        w_left--;
      end
    end else begin
      armed      = 1'b0;
      bus.DM_ACK = 1'($urandom_range(0, 1));
      bus.DM_IN  = DATA_W'($urandom);
    end
  end

  function automatic logic [INSTR_W-1:0] ins(input logic [4:0] op, input logic [10:0] opd);
    return {op, opd};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < PM_SIZE; i++) rom[i] = ins(OP_NOP, 11'h000);
  endtask

  task automatic begin_reset();
    RESET = 1'b0;
    #1;
    waits_q.delete();
  endtask

  // Hold reset for three clocks, check reset state, release on a falling edge.
  task automatic end_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pc",     32'(bus.ADDR_PM), 32'h0);
    check("rst_acc",    32'(acc),         32'h0);
    check("rst_rdwr",   {bus.RD, bus.WR}, 32'h0);
    check("rst_cycles", 32'(cycles),      32'h0);
    check("rst_halted", 32'(halted),      32'h0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Random program, executed first by the instruction-level model (which
  // also chooses the wait states) and then by the DUT.
  task automatic run_random(input int run);
    logic [DATA_W-1:0] mram [16];
    logic [DATA_W-1:0] m_acc;
    logic [DATA_W-1:0] imm;
    logic [4:0]        op;
    logic [10:0]       opd;
    int                m_pc;
    int                m_cyc;
    int                w;
    int                n;
    bit                m_z;
    bit                done;
    bit                jump;

    begin_reset();
    fill_nop();
    for (int i = 0; i < 16; i++) begin
      ram[i]  = DATA_W'($urandom);
      mram[i] = ram[i];
    end
    for (int i = 0; i < PLEN; i++) begin
      case ($urandom_range(0, 11))
        0, 10:   rom[i] = ins(OP_LDI,  11'($urandom));
        1:       rom[i] = ins(OP_ADDI, 11'($urandom));
        2:       rom[i] = ins(OP_SUBI, 11'($urandom));
        3, 7:    rom[i] = ins(OP_STO,  11'($urandom_range(0, 15)));
        4, 11:   rom[i] = ins(OP_LD,   11'($urandom_range(0, 15)));
        5:       rom[i] = ins(OP_ADD,  11'($urandom_range(0, 15)));
        6:       rom[i] = ins(OP_SUB,  11'($urandom_range(0, 15)));
        9:       rom[i] = ins(5'(OP_BEQ + $urandom_range(0, 2)), 11'($urandom_range(i + 1, PLEN)));
        default: rom[i] = ins(5'($urandom_range(11, 31)), 11'($urandom));
      endcase
    end
    rom[PLEN] = ins(OP_HLT, 11'h000);

    m_pc = 0; m_acc = '0; m_z = 1'b1; m_cyc = 0; done = 1'b0;
    while (!done) begin
      op   = rom[m_pc][15:11];
      opd  = rom[m_pc][10:0];
      imm  = DATA_W'($signed(opd));
      jump = 1'b0;
      m_cyc++;
      if (op inside {OP_STO, OP_LD, OP_ADD, OP_SUB}) begin
        w = $urandom_range(0, 3);
        waits_q.push_back(w);
        m_cyc += w + 1;
      end
      case (op)
        OP_HLT:  done = 1'b1;
        OP_LDI:  m_acc = imm;
        OP_ADDI: m_acc = m_acc + imm;
        OP_SUBI: m_acc = m_acc - imm;
        OP_STO:  mram[opd[3:0]] = m_acc;
        OP_LD:   m_acc = mram[opd[3:0]];
        OP_ADD:  m_acc = m_acc + mram[opd[3:0]];
        OP_SUB:  m_acc = m_acc - mram[opd[3:0]];
`ifdef BIP_BRANCH_EN
        OP_BEQ:  jump = m_z;
        OP_BNE:  jump = !m_z;
        OP_JMP:  jump = 1'b1;
`endif
        default: ;
      endcase
      if (jump)       m_pc = int'(opd);
      else if (!done) m_pc = (m_pc + 1) % PM_SIZE;
      m_z = (m_acc == '0);
    end

    end_reset();
    n = 0;
    while (!halted && n < 4000) begin
      tick(1);
      n++;
    end
    check($sformatf("rnd%0d_halted", run), 32'(halted),      32'h1);
    check($sformatf("rnd%0d_acc",    run), 32'(acc),         32'(m_acc));
    check($sformatf("rnd%0d_pc",     run), 32'(bus.ADDR_PM), 32'(m_pc));
    check($sformatf("rnd%0d_cycles", run), 32'(cycles),      32'(m_cyc));
    for (int i = 0; i < 16; i++)
      check($sformatf("rnd%0d_ram%0d", run, i), 32'(ram[i]), 32'(mram[i]));
  endtask

  int cnt;

  initial begin
    #1;
    RESET = 1'b0;

    // Reset, one NOP, counter saturation on the 4-bit instance.
    begin_reset();
    fill_nop();
    end_reset();
    tick(1);
    check("nop_pc",      32'(bus.ADDR_PM), 32'h1);
    check("nop_cycles",  32'(cycles),      32'h1);
    check("sat_start",   32'(cycles_s),    32'h1);
    tick(20);
    check("sat_cycles",  32'(cycles_s),    32'hF);
    check("nop_cycles2", 32'(cycles),      32'd21);

    // Immediates with sign extension.
    begin_reset();
    fill_nop();
    rom[0] = ins(OP_LDI,  11'h005);
    rom[1] = ins(OP_ADDI, 11'h7FF);
    rom[2] = ins(OP_SUBI, 11'h003);
    rom[3] = ins(OP_HLT,  11'h000);
    end_reset();
    tick(1); check("ldi_acc",  32'(acc), 32'h5); check("ldi_pc",  32'(bus.ADDR_PM), 32'h1);
    tick(1); check("addi_acc", 32'(acc), 32'h4); check("addi_pc", 32'(bus.ADDR_PM), 32'h2);
    tick(1); check("subi_acc", 32'(acc), 32'h1); check("subi_pc", 32'(bus.ADDR_PM), 32'h3);
    tick(1); check("hlt_halted", 32'(halted), 32'h1); check("hlt_cycles", 32'(cycles), 32'h4);

    // Load with three wait states.
    begin_reset();
    fill_nop();
    rom[0] = ins(OP_LD, 11'h010);
    ram[16] = 16'h1234;
    waits_q.push_back(3);
    end_reset();
    tick(1);
    check("ld_addr", 32'(bus.ADDR_DM), 32'h010);
    cnt = 0;
    while (bus.RD && cnt < 20) begin
      if (bus.ADDR_PM != '0) check("ld_pc_hold", 32'(bus.ADDR_PM), 32'h0);
      cnt++;
      tick(1);
    end
    check("ld_rd_cycles", 32'(cnt),         32'd4);
    check("ld_acc",       32'(acc),         32'h1234);
    check("ld_pc",        32'(bus.ADDR_PM), 32'h1);

    // Store of 0xBEEF to the top address, then halt and freeze.
    begin_reset();
    fill_nop();
    ram[32] = 16'hBEEF;
    ram[2047] = 16'h0000;
    rom[0] = ins(OP_LD,  11'h020);
    rom[1] = ins(OP_STO, 11'h7FF);
    rom[2] = ins(OP_HLT, 11'h000);
    waits_q.push_back(0);
    waits_q.push_back(0);
    end_reset();
    tick(2); check("sto_acc", 32'(acc), 32'hBEEF);
    tick(1);
    check("sto_wr",   32'({bus.RD, bus.WR}), 32'h1);
    check("sto_addr", 32'(bus.ADDR_DM),      32'h7FF);
    check("sto_dout", 32'(bus.DM_OUT),       32'hBEEF);
    tick(1); check("sto_wr_drop", 32'(bus.WR), 32'h0); check("sto_pc", 32'(bus.ADDR_PM), 32'h2);
    check("sto_ram", 32'(ram[2047]), 32'hBEEF);
    tick(1); check("sto_halted", 32'(halted), 32'h1); check("sto_cycles", 32'(cycles), 32'h5);
    tick(5);
    check("halt_pc",     32'(bus.ADDR_PM),      32'h2);
    check("halt_cycles", 32'(cycles),           32'h5);
    check("halt_rdwr",   {bus.RD, bus.WR},      32'h0);

    // Accumulator and PC wrap-around.
    begin_reset();
    fill_nop();
    rom[0] = ins(OP_LDI,  11'h7FF);
    rom[1] = ins(OP_ADDI, 11'h001);
    end_reset();
    tick(1); check("wrap_acc_ff", 32'(acc), 32'hFFFF);
    tick(1); check("wrap_acc_0",  32'(acc), 32'h0);
    tick(2045); check("wrap_pc_top", 32'(bus.ADDR_PM), 32'h7FF);
    tick(1);    check("wrap_pc_0",   32'(bus.ADDR_PM), 32'h000);

    // Branches, or their NOP behaviour without the feature.
    begin_reset();
    fill_nop();
`ifdef BIP_BRANCH_EN
    rom[0]     = ins(OP_LDI, 11'h000);
    rom[1]     = ins(OP_BEQ, 11'h020);
    rom[32]    = ins(OP_LDI, 11'h001);
    rom[33]    = ins(OP_BEQ, 11'h040);
    rom[34]    = ins(OP_JMP, 11'h005);
    rom[5]     = ins(OP_BNE, 11'h100);
    end_reset();
    tick(2); check("beq_taken",    32'(bus.ADDR_PM), 32'h020);
    tick(2); check("beq_fall",     32'(bus.ADDR_PM), 32'h022);
    tick(1); check("jmp_pc",       32'(bus.ADDR_PM), 32'h005);
    tick(1); check("bne_taken",    32'(bus.ADDR_PM), 32'h100);
`else
    rom[0] = ins(OP_JMP, 11'h005);
    rom[1] = ins(OP_BEQ, 11'h020);
    end_reset();
    tick(1); check("jmp_nop_pc", 32'(bus.ADDR_PM), 32'h001);
    tick(1); check("beq_nop_pc", 32'(bus.ADDR_PM), 32'h002);
`endif

    // Reset during a pending read drops the request at once.
    begin_reset();
    fill_nop();
    rom[0] = ins(OP_LD, 11'h010);
    waits_q.push_back(10);
    end_reset();
    tick(2);
    check("abort_rd_before", 32'(bus.RD), 32'h1);
    RESET = 1'b0;
    #1;
    check("abort_rd",     32'({bus.RD, bus.WR}), 32'h0);
    check("abort_addr",   32'(bus.ADDR_DM),      32'h0);
    check("abort_cycles", 32'(cycles),           32'h0);

    // Random programs against the instruction-level model.
    for (int r = 0; r < N_RUNS; r++) run_random(r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
